// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline.
// Resolves operand forwarding, builds Val2 from the shifter operand, runs the
// ALU, computes the branch target and holds the NZCV status register.
// Everything except the status register is combinational into EX/MEM.
module exe_stage #(
    parameter logic [3:0] STATUS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [3:0]  EXE_CMD,
    input  logic        S,
    input  logic        B,
    input  logic        imm,
    input  logic        Mem_R_EN,
    input  logic        Mem_W_EN,
    input  logic        C_in,
    input  logic [31:0] pc,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] signed_imm_24,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    output logic [31:0] alu_result,
    output logic [31:0] st_val,
    output logic [31:0] br_addr,
    output logic        br_taken,
    output logic [3:0]  status
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // Rotate right; a zero amount leaves x untouched because x << 32 is zero.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] shifted;
    logic [31:0] val2;
    logic [32:0] sum;
    logic [31:0] res;
    logic        flag_c;
    logic        flag_v;

    // Forwarding muxes; select 11 is unused and falls back to the register file.
    always_comb begin
        case (sel_src1)
            2'b01:   op1 = mem_fwd_val;
            2'b10:   op1 = wb_fwd_val;
            default: op1 = Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   op2 = mem_fwd_val;
            2'b10:   op2 = wb_fwd_val;
            default: op2 = Val_Rm;
        endcase
    end

    assign st_val = op2;

    // Val2: memory offset beats rotated immediate beats shifted register.
    always_comb begin
        shifted = op2;
        if (shift_operand[11:7] != 5'd0) begin
            case (shift_operand[6:5])
                2'b00:   shifted = op2 << shift_operand[11:7];
                2'b01:   shifted = op2 >> shift_operand[11:7];
                2'b10:   shifted = $unsigned($signed(op2) >>> shift_operand[11:7]);
                default: shifted = ror32(op2, shift_operand[11:7]);
            endcase
        end
        if (Mem_R_EN || Mem_W_EN)
            val2 = {20'b0, shift_operand};
        else if (imm)
            val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
        else
            val2 = shifted;
    end

    // ALU; subtraction is done as op1 + ~val2 + carry so bit 32 is the no-borrow flag.
    always_comb begin
        sum    = '0;
        res    = '0;
        flag_c = status[1];
        flag_v = status[0];
        case (EXE_CMD)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum    = {1'b0, op1} + {1'b0, val2} + {32'b0, (EXE_CMD == CMD_ADC) && C_in};
                res    = sum[31:0];
                flag_c = sum[32];
                flag_v = (op1[31] == val2[31]) && (res[31] != op1[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum    = {1'b0, op1} + {1'b0, ~val2} + {32'b0, (EXE_CMD == CMD_SUB) || C_in};
                res    = sum[31:0];
                flag_c = sum[32];
                flag_v = (op1[31] != val2[31]) && (res[31] != op1[31]);
            end
            CMD_AND: res = op1 & val2;
            CMD_ORR: res = op1 | val2;
            CMD_EOR: res = op1 ^ val2;
            default: res = '0;
        endcase
    end

    assign alu_result = res;
    assign br_addr    = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
    assign br_taken   = B;

    // Status register: loads new NZCV on S unless the pipeline is frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status <= STATUS_RST;
        else if (S && !freeze)
            status <= {res[31], (res == 32'd0), flag_c, flag_v};
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes the ID/EX pipeline register outputs.
- Generates Val2 from the shifter operand, runs the ALU, computes the branch target and holds the NZCV status register.
- Results go combinationally to the EX/MEM register; the status register output feeds back to the ID-stage condition check.

Parameters:
- STATUS_RST, 4'b0000, reset value of status register {N,Z,C,V}

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (clears state while low)
- freeze  in  1  hazard stall; blocks status update
- EXE_CMD  in  4  ALU operation code
- S  in  1  update status when set
- B  in  1  branch instruction
- imm  in  1  immediate operand form
- Mem_R_EN  in  1  load
- Mem_W_EN  in  1  store
- C_in  in  1  carry captured in ID/EX register
- pc  in  32  PC+4 of instruction
- Val_Rn  in  32  register Rn value
- Val_Rm  in  32  register Rm value
- shift_operand  in  12  instruction bits [11:0]
- signed_imm_24  in  24  branch offset
- sel_src1  in  2  forwarding select for Rn
- sel_src2  in  2  forwarding select for Rm
- mem_fwd_val  in  32  ALU result in MEM stage
- wb_fwd_val  in  32  write-back value
- alu_result  out  32  ALU result
- st_val  out  32  forwarded Rm (store data)
- br_addr  out  32  branch target
- br_taken  out  1  equals B
- status  out  4  registered {N,Z,C,V}

Behaviour:
- Forwarding: sel 00 -> Val_Rn/Val_Rm; 01 -> mem_fwd_val; 10 -> wb_fwd_val; 11 -> treated as 00. st_val = forwarded Rm.
- Val2 priority (first match wins):
  - Mem_R_EN or Mem_W_EN: zero-extended shift_operand[11:0].
  - imm=1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - Otherwise: forwarded Rm shifted by shift_operand[11:7] with type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 passes Rm unchanged.
- ALU, Op1 = forwarded Rn, C = C_in:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD/LDR/STR: Op1+Val2
  - 0011 ADC: Op1+Val2+C
  - 0100 SUB/CMP: Op1-Val2
  - 0101 SBC: Op1-Val2-~C
  - 0110 AND/TST: Op1&Val2
  - 0111 ORR: Op1|Val2
  - 1000 EOR: Op1^Val2
  - Other codes: result 0.
- Flags:
  - N = result[31]; Z = (result == 0).
  - Add ops: C = bit 32 of the 33-bit sum; V = (a[31]==b[31]) and (r[31]!=a[31]).
  - Sub ops: C = no-borrow; V = (a[31]!=b[31]) and (r[31]!=a[31]).
  - Logic, MOV, MVN: C and V keep the current status bits.
- br_addr = pc + (sign-extended signed_imm_24 << 2), modulo 2^32. Computed every cycle regardless of B.
- Status register:
  - Loads {N,Z,C,V} on the rising edge when S=1 and freeze=0; otherwise holds.
  - Reset low -> STATUS_RST immediately, including mid-operation.
  - An update and reset release on the same edge: reset wins.
- Latency: all outputs except status are combinational (0 cycles). status reflects the instruction one cycle after it is present.
- Reset values: status = STATUS_RST. Combinational outputs follow their inputs; with ID/EX zeroed they read alu_result=0, br_addr=0, br_taken=0, st_val=0.

Test Plan:
- Reset: rst=0 mid-run with S=1 -> status=0000 immediately; stays 0000 while low.
- ADD flags: Rn=32'h7FFFFFFF, imm=1, shift_operand=12'h001, CMD=0010, S=1 -> alu_result=32'h80000000; next cycle status=1001 (N=1, V=1).
- Compare: CMD=0100, Rn=5, Rm=5, reg form LSL #0, S=1 -> status=0110. Repeat with freeze=1 -> status unchanged.
- Shifter and immediate:
  - Rm=32'h80000001, shift_operand ROR #1 (12'h0E0), MOV -> 32'hC0000000.
  - ASR #4 (12'h240) -> 32'hF8000000.
  - imm=1, shift_operand=12'h4FF -> 32'hFF000000.
- Forwarding: sel_src1=01 with mem_fwd_val=100, sel_src2=10 with wb_fwd_val=3, CMD=0101, C_in=0 -> alu_result=96, st_val=3.
- Branch: pc=32'h100, signed_imm_24=24'hFFFFFE, B=1 -> br_addr=32'h0F8, br_taken=1.
